instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encodes decoded RV32I fields (opcode, registers, funct3, signed immediate) into a 32-bit instruction word, then writes it sequentially into instruction memory.
- Inverse of the decode-side immediate path. Covers the same opcode set: OP-IMM, LOAD, JALR, STORE, BRANCH, JAL.
- Sits between the test/boot loader front end and instruction memory.
- Performs immediate range checking and tracks the write pointer and word count.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- MAX_WORDS, 256, number of instructions accepted before `full`.
- CNT_W, 9, width of `count`. Must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  restarts address pointer and count. Sampled only in IDLE or FULL.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle. Equals (state==IDLE).
- opcode  in  7  instruction opcode.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- imm  in  32  signed immediate. BRANCH and JAL values are in halfword units (byte offset >> 1).
- mem_we  out  1  memory write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  32  byte address of the current write.
- mem_wdata  out  32  encoded instruction.
- err_valid  out  1  one-cycle pulse: bundle rejected.
- err_code  out  2  01 = illegal opcode, 10 = immediate out of range. Holds its value until the next error.
- count  out  CNT_W  instructions written since reset or clear.
- full  out  1  count == MAX_WORDS.

Behaviour:
- Reset (async, rst_n=0) values:
  - state = IDLE, in_ready = 1
  - mem_we = 0, mem_wdata = 0, mem_addr = BASE_ADDR
  - err_valid = 0, err_code = 00
  - count = 0, full = 0
- Reset during CHECK or WRITE aborts the operation; no write is completed.
- States: IDLE, CHECK, WRITE, FULL.
- IDLE:
  - in_valid && in_ready at edge N: latch all fields and go to CHECK.
  - clear: count = 0, mem_addr = BASE_ADDR, stay IDLE. clear has priority over in_valid in the same cycle.
- CHECK (one cycle): classify the opcode.
  - I format: 0010011, 0000011, 1100111.
  - S format: 0100011.
  - B format: 1100011.
  - J format: 1101111.
  - Any other opcode: err_code = 01.
  - Range rule, I/S/B: imm[31:11] all equal. J: imm[31:19] all equal. Violation gives err_code = 10.
  - Opcode error has priority over range error.
  - On error: err_valid = 1 for the next cycle only; return to IDLE; no write; count and address unchanged.
  - On success: register mem_wdata, set mem_we = 1, go to WRITE.
  - Result: mem_we first high at edge N+2; error pulse visible in cycle N+2.
- Encoding of mem_wdata ({} is concatenation, MSB first):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}
  - J: {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode}
  - Unused fields (rs2 for I/J, rd for S/B, funct3 for J) are ignored.
- WRITE:
  - mem_we, mem_addr and mem_wdata are held stable until mem_ready.
  - On an edge with mem_we && mem_ready: mem_we = 0; mem_addr += 4 (32-bit wrap); count += 1.
  - Then go to FULL if the new count == MAX_WORDS, else IDLE.
  - A mem_ready that is already high on entry completes the write in a single cycle.
- FULL:
  - in_ready = 0 and full = 1.
  - clear: count = 0, mem_addr = BASE_ADDR, full = 0, go to IDLE.
- clear in CHECK or WRITE is ignored; the source must hold it until IDLE or FULL.
- Throughput: one instruction per 3 cycles minimum.

Test Plan:
- addi x1,x2,-1: opcode=0010011, rd=1, rs1=2, funct3=0, imm=32'hFFFFFFFF, mem_ready tied 1.
  → mem_wdata = 32'hFFF10093 at mem_addr 0x0; count = 1.
- sw x5,8(x6) (opcode=0100011, rs1=6, rs2=5, funct3=2, imm=8), then beq x1,x2,+16 (opcode=1100011, rs1=1, rs2=2, funct3=0, imm=8).
  → words 32'h00532423, then 32'h00208863; addresses 0x0 and 0x4.
- jal x1,+2048 (opcode=1101111, rd=1, imm=1024) → 32'h001000EF.
  - Round trip: the decoded immediate of each written word equals the input imm.
- Error cases:
  - imm=2048 with I format → err_valid pulse, err_code = 10, no mem_we, count unchanged.
  - opcode=0110011 → err_code = 01.
- Back-pressure and reset:
  - mem_ready low for 5 cycles → mem_we and mem_wdata stable throughout; count increments exactly once.
  - rst_n low mid-WRITE → all outputs return to reset values.
- Full and clear, with MAX_WORDS=4:
  - After 4 writes: full = 1, in_ready = 0.
  - clear → count = 0; next write lands at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field encoder: checks a decoded field bundle, packs it into a 32-bit
// instruction word and writes it sequentially into instruction memory.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_FULL} state_e;
    typedef enum logic [1:0] {F_I, F_S, F_B, F_J} fmt_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_e           state_q;
    logic [6:0]       op_q;
    logic [4:0]       rd_q, rs1_q, rs2_q;
    logic [2:0]       f3_q;
    logic [31:0]      imm_q;
    logic             mem_we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             err_valid_q;
    logic [1:0]       err_code_q;
    logic [CNT_W-1:0] count_q;

    fmt_e             fmt;
    logic             op_ok;
    logic             range_ok;
    logic [31:0]      word_d;
    logic [CNT_W-1:0] count_d;

    // Classify the latched opcode and build the candidate word during CHECK.
    always_comb begin
        fmt    = F_I;
        op_ok  = 1'b1;
        word_d = 32'h0;
        case (op_q)
            7'b0010011, 7'b0000011, 7'b1100111: fmt = F_I;
            7'b0100011:                         fmt = F_S;
            7'b1100011:                         fmt = F_B;
            7'b1101111:                         fmt = F_J;
            default:                            op_ok = 1'b0;
        endcase
        // Immediate must sign-extend from its encodable width (12 bits, or 20 for J).
        if (fmt == F_J)
            range_ok = (&imm_q[31:19]) | ~(|imm_q[31:19]);
        else
            range_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
        case (fmt)
            F_I: word_d = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
            F_S: word_d = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
            F_B: word_d = {imm_q[11], imm_q[9:4], rs2_q, rs1_q, f3_q,
                           imm_q[3:0], imm_q[10], op_q};
            F_J: word_d = {imm_q[19], imm_q[9:0], imm_q[10], imm_q[18:11], rd_q, op_q};
            default: word_d = 32'h0;
        endcase
    end

    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 7'h0;
            rd_q        <= 5'h0;
            rs1_q       <= 5'h0;
            rs2_q       <= 5'h0;
            f3_q        <= 3'h0;
            imm_q       <= 32'h0;
            mem_we_q    <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'h0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            count_q     <= '0;
        end else begin
            err_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        count_q <= '0;
                        addr_q  <= BASE_ADDR;
                    end else if (in_valid) begin
                        op_q    <= opcode;
                        rd_q    <= rd;
                        rs1_q   <= rs1;
                        rs2_q   <= rs2;
                        f3_q    <= funct3;
                        imm_q   <= imm;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!op_ok) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= 2'b01;
                        state_q     <= S_IDLE;
                    end else if (!range_ok) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= 2'b10;
                        state_q     <= S_IDLE;
                    end else begin
                        wdata_q  <= word_d;
                        mem_we_q <= 1'b1;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_we_q <= 1'b0;
                        addr_q   <= addr_q + 32'd4;
                        count_q  <= count_d;
                        state_q  <= (count_d == MAX_CNT) ? S_FULL : S_IDLE;
                    end
                end
                S_FULL: begin
                    if (clear) begin
                        count_q <= '0;
                        addr_q  <= BASE_ADDR;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign full      = (state_q == S_FULL);
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized bundles
// checked every cycle against a transaction-level model of writes and errors.
module tb_instr_encoder;

    localparam int          MAXW = 4;
    localparam int          CW   = 3;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear, in_valid, in_ready;
    logic [6:0]    opcode;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    funct3;
    logic [31:0]   imm;
    logic          mem_we, mem_ready;
    logic [31:0]   mem_addr, mem_wdata;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [CW-1:0] count;
    logic          full;

    instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_valid(err_valid),
        .err_code(err_code), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int low_until = 0;
    bit rdy_rand  = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cyc < low_until)  mem_ready = 1'b0;
        else if (rdy_rand)    mem_ready = 1'($urandom_range(0, 1));
        else                  mem_ready = 1'b1;
    end

    typedef struct {
        logic [31:0] data;
        logic [31:0] imm;
        int          fmt;
    } wr_t;

    wr_t         exp_w[$];
    logic [1:0]  exp_e[$];
    int          widx = 0, eidx = 0;
    int          m_count = 0;
    logic [31:0] m_addr = BASE;
    logic [1:0]  m_code = 2'b00;
    int          checks = 0, fails = 0;
    int          bnd[8] = '{2047, 2048, -2048, -2049, 524287, 524288, -524288, -524289};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 = illegal, 1 = I, 2 = S, 3 = B, 4 = J
    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            7'b1101111: return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [1:0] err_of(input logic [6:0] op, input logic [31:0] im);
        int f, v, lim;
        f   = fmt_of(op);
        v   = im;
        lim = (f == 4) ? 524288 : 2048;
        if (f == 0) return 2'b01;
        if (v < -lim || v >= lim) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] enc(input int f, input logic [6:0] op, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [2:0] f3, input logic [31:0] im);
        logic [31:0] w, r1, r2, dw, fw;
        r1 = 32'(s1); r2 = 32'(s2); dw = 32'(d); fw = 32'(f3);
        w  = 32'(op);
        case (f)
            1: w |= ((im & 32'hFFF) << 20) | (r1 << 15) | (fw << 12) | (dw << 7);
            2: w |= (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (fw << 12)
                  | ((im & 32'h1F) << 7);
            3: w |= (((im >> 11) & 32'h1) << 31) | (((im >> 4) & 32'h3F) << 25) | (r2 << 20)
                  | (r1 << 15) | (fw << 12) | ((im & 32'hF) << 8) | (((im >> 10) & 32'h1) << 7);
            4: w |= (((im >> 19) & 32'h1) << 31) | ((im & 32'h3FF) << 21)
                  | (((im >> 10) & 32'h1) << 20) | (((im >> 11) & 32'hFF) << 12) | (dw << 7);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Standard decode-side immediate extraction (B/J in halfword units).
    function automatic logic [31:0] dec(input int f, input logic [31:0] w);
        case (f)
            1: return {{20{w[31]}}, w[31:20]};
            2: return {{20{w[31]}}, w[31:25], w[11:7]};
            3: return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            4: return {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic monitor();
        logic        pv_we = 1'b0, pv_rdy = 1'b0;
        logic [31:0] pv_d = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_count = 0; m_addr = BASE; m_code = 2'b00;
                widx = exp_w.size(); eidx = exp_e.size();
                pv_we = 1'b0;
                continue;
            end
            chk("count", 32'(count), m_count);
            chk("full", 32'(full), 32'(m_count == MAXW));
            chk("mem_addr", mem_addr, m_addr);
            if (mem_we || full) chk("in_ready_busy", 32'(in_ready), 0);
            if (pv_we && !pv_rdy) begin
                chk("we_hold", 32'(mem_we), 1);
                chk("wdata_hold", mem_wdata, pv_d);
            end
            if (err_valid) begin
                if (eidx >= exp_e.size()) chk("err_extra", 32'(err_valid), 0);
                else begin m_code = exp_e[eidx]; eidx++; end
            end
            chk("err_code", 32'(err_code), 32'(m_code));
            if (mem_we) begin
                if (widx >= exp_w.size()) chk("we_extra", 32'(mem_we), 0);
                else begin
                    chk("wdata", mem_wdata, exp_w[widx].data);
                    if (mem_ready) begin
                        chk("roundtrip", dec(exp_w[widx].fmt, mem_wdata), exp_w[widx].imm);
                        widx++; m_addr += 32'd4; m_count++;
                    end
                end
            end
            if (clear && (in_ready || full)) begin m_count = 0; m_addr = BASE; end
            pv_we = mem_we; pv_rdy = mem_ready; pv_d = mem_wdata;
        end
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im,
                        input bit wait_done);
        int n = 0;
        logic [1:0] e;
        wr_t w;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ready_wait", 32'(in_ready), 1);
        if (!in_ready) return;
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im; in_valid = 1'b1;
        e = err_of(op, im);
        if (e != 2'b00) exp_e.push_back(e);
        else begin
            w.data = enc(fmt_of(op), op, d, s1, s2, f3, im);
            w.imm  = im;
            w.fmt  = fmt_of(op);
            exp_w.push_back(w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); funct3 = 3'($urandom); imm = $urandom;
        chk("check_busy", 32'(in_ready), 0);
        chk("check_we", 32'(mem_we), 0);
        chk("check_err", 32'(err_valid), 0);
        @(posedge clk); #1;
        chk("lat_err", 32'(err_valid), 32'(e != 2'b00));
        chk("lat_we", 32'(mem_we), 32'(e == 2'b00));
        if (wait_done) begin
            n = 0;
            while (mem_we && n < 200) begin @(posedge clk); #1; n++; end
            chk("write_done", 32'(mem_we), 0);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_addr"}, mem_addr, BASE);
        chk({tag, "_err_valid"}, 32'(err_valid), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_full"}, 32'(full), 0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] im;
        int          k;
        int          c0;
        clear = 1'b0; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; imm = '0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
        chk("addi_word", mem_wdata, 32'hFFF1_0093);
        chk("addi_count", 32'(count), 1);
        chk("addi_next_addr", mem_addr, 32'h4);
        do_clear();
        chk("clr_count", 32'(count), 0);
        chk("clr_addr", mem_addr, BASE);

        send(7'b0100011, 5'd0, 5'd6, 5'd5, 3'd2, 32'd8, 1'b1);
        chk("sw_word", mem_wdata, 32'h0053_2423);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8, 1'b1);
        chk("beq_word", mem_wdata, 32'h0020_8863);
        chk("beq_next_addr", mem_addr, 32'h8);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1024, 1'b1);
        chk("jal_word", mem_wdata, 32'h0010_00EF);

        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048, 1'b1);
        chk("range_code", 32'(err_code), 2'b10);
        chk("range_count", 32'(count), 3);
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 1'b1);
        chk("opc_code", 32'(err_code), 2'b01);
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h8000_0000, 1'b1);
        chk("opc_prio_code", 32'(err_code), 2'b01);

        send(7'b0000011, 5'd3, 5'd4, 5'd0, 3'd2, 32'hFFFF_F800, 1'b1);
        chk("full_flag", 32'(full), 1);
        chk("full_ready", 32'(in_ready), 0);
        do_clear();
        chk("full_clr_count", 32'(count), 0);
        chk("full_clr_flag", 32'(full), 0);
        chk("full_clr_ready", 32'(in_ready), 1);
        send(7'b0010011, 5'd7, 5'd8, 5'd0, 3'd0, 32'd5, 1'b1);
        chk("after_clr_addr", mem_addr, BASE + 32'h4);

        c0 = count;
        low_until = cyc + 9;
        send(7'b0100011, 5'd0, 5'd9, 5'd10, 3'd2, 32'hFFFF_FFF0, 1'b1);
        chk("bp_count", 32'(count), 32'(c0 + 1));

        low_until = cyc + 40;
        send(7'b1101111, 5'd2, 5'd0, 5'd0, 3'd0, 32'hFFF8_0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("midwr_we", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("midwr");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        low_until = 0;
        @(posedge clk); #1;

        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (full || $urandom_range(0, 15) == 0) do_clear();
            case ($urandom_range(0, 7))
                0: op = 7'b0010011;
                1: op = 7'b0000011;
                2: op = 7'b1100111;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                5, 6: op = 7'b1101111;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: begin k = $urandom_range(0, 4095); im = k - 2048; end
                1: im = bnd[$urandom_range(0, 7)];
                2: begin k = $urandom_range(0, 1048575); im = k - 524288; end
                3: im = $urandom;
                4: im = 32'h1 << $urandom_range(0, 31);
                default: begin k = $urandom_range(0, 31); im = k - 16; end
            endcase
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), im, 1'b1);
        end
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("writes_drained", widx, exp_w.size());
        chk("errors_drained", eidx, exp_e.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
